// File: rtl/uart_rx_if.sv
// Serial receive bus: the raw line going into the receiver and the
// byte/strobe outputs coming back to the consumer.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;

  // Line driver / byte consumer side
  modport master (
    output rx,
    input  dout,
    input  rx_done_tick,
    input  frame_err
  );

  // Receiver side
  modport slave (
    input  rx,
    output dout,
    output rx_done_tick,
    output frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, 2-flop input synchronizer and
// one-cycle done / framing-error strobes.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s to go low
// START | counting to the middle of the start bit, rejecting glitches
// DATA  | sampling DBIT data bits at mid-bit, LSB first
// STOP  | counting through the stop bit, sampling it at the end
module uart_rx #(
  parameter int CLK_DIV = 163,
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  uart_rx_if.slave bus
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [CW-1:0]   tick_cnt;
  logic            s_tick;
  logic [1:0]      sync;
  logic            rx_s;
  logic [3:0]      s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic [DBIT-1:0] dout_q;
  logic            done_q;
  logic            ferr_q;

  assign s_tick = (tick_cnt == CW'(CLK_DIV - 1));
  assign rx_s   = sync[1];

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;

  // Free-running oversample tick divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tick_cnt <= '0;
    else if (s_tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + CW'(1);
  end

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sync <= 2'b11;
    else
      sync <= {sync[0], bus.rx};
  end

  // Receive FSM with registered byte and strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      s      <= '0;
      n      <= '0;
      b      <= '0;
      dout_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state)
        IDLE: begin
          // Start edge is looked for every clk so a frame can follow
          // immediately after the previous stop sample.
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == 4'd7) begin
              s <= '0;
              if (!rx_s) begin
                state <= DATA;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == 4'd15) begin
              s <= '0;
              b <= {rx_s, b[DBIT-1:1]};
              if (n == NW'(DBIT - 1))
                state <= STOP;
              else
                n <= n + NW'(1);
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == 4'(SB_TICK - 1)) begin
              state <= IDLE;
              s     <= '0;
              if (rx_s) begin
                dout_q <= b;
                done_q <= 1'b1;
              end else begin
                ferr_q <= 1'b1;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_DIV=4 (one bit = 64 clk).
module tb_uart_rx;

  localparam int BIT_CLK = 64;
  localparam int GAP     = 120;

  logic clk;
  logic rst_n;

  uart_rx_if #(.DBIT(8)) bus ();

  uart_rx #(.CLK_DIV(4), .DBIT(8), .SB_TICK(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Observed-event model: strobe counters, captured bytes, pulse widths
  // and a 5-entry downstream buffer fed by rx_done_tick.
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         run_len  = 0;
  int         max_run  = 0;
  logic [7:0] cap_q[$];
  logic [7:0] fifo[5];
  int         fifo_cnt  = 0;
  bit         fifo_full = 1'b0;
  bit         fifo_en   = 1'b0;

  always @(negedge clk) begin
    if (bus.rx_done_tick) begin
      done_cnt++;
      cap_q.push_back(bus.dout);
      if (fifo_en && fifo_cnt < 5) begin
        fifo[fifo_cnt] = bus.dout;
        fifo_cnt++;
        if (fifo_cnt == 5) fifo_full = 1'b1;
      end
    end
    if (bus.frame_err) ferr_cnt++;
    if (bus.rx_done_tick && bus.frame_err) both_cnt++;
    if (bus.rx_done_tick || bus.frame_err) run_len++;
    else run_len = 0;
    if (run_len > max_run) max_run = run_len;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Bad stop bits are held low only past the mid-bit sample so that the
  // rising line afterwards is rejected as a start glitch.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) hold(d[i], BIT_CLK);
    if (stop_bit) begin
      hold(1'b1, BIT_CLK);
    end else begin
      hold(1'b0, 40);
      hold(1'b1, BIT_CLK - 40);
    end
  endtask

  typedef struct {
    int         kind;      // 0 = frame, 1 = 20-clk low glitch
    logic [7:0] data;
    logic       stop_bit;
    int         exp_done;
    int         exp_ferr;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int d0, f0, q0, v0, v1;

    vecs[0] = '{0, 8'h7E, 1'b0, 0, 1, 8'h00};
    vecs[1] = '{0, 8'h55, 1'b1, 1, 0, 8'h55};
    vecs[2] = '{1, 8'h00, 1'b1, 0, 0, 8'h55};
    vecs[3] = '{0, 8'h00, 1'b1, 1, 0, 8'h00};
    vecs[4] = '{0, 8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[5] = '{0, 8'h81, 1'b0, 0, 1, 8'hFF};
    vecs[6] = '{0, 8'h80, 1'b1, 1, 0, 8'h80};

    rst_n  = 1'b0;
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_dout", int'(bus.dout), 0);
    check("reset_done", int'(bus.rx_done_tick), 0);
    check("reset_ferr", int'(bus.frame_err), 0);
    rst_n = 1'b1;
    hold(1'b1, 20);

    for (int i = 0; i < 7; i++) begin
      d0 = done_cnt;
      f0 = ferr_cnt;
      if (vecs[i].kind == 0) send_frame(vecs[i].data, vecs[i].stop_bit);
      else hold(1'b0, 20);
      hold(1'b1, GAP);
      check($sformatf("vec%0d_done", i), done_cnt - d0, vecs[i].exp_done);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_dout", i), int'(bus.dout), int'(vecs[i].exp_dout));
    end

    // Back-to-back frames with no idle gap
    d0 = done_cnt;
    f0 = ferr_cnt;
    q0 = cap_q.size();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h3C, 1'b1);
    hold(1'b1, GAP);
    check("b2b_done", done_cnt - d0, 2);
    check("b2b_ferr", ferr_cnt - f0, 0);
    v0 = (cap_q.size() > q0) ? int'(cap_q[q0]) : -1;
    v1 = (cap_q.size() > q0 + 1) ? int'(cap_q[q0 + 1]) : -1;
    check("b2b_first", v0, 8'hA3);
    check("b2b_second", v1, 8'h3C);

    // Reset in the middle of data bit 4 of 0xFF, then a clean 0x12
    d0 = done_cnt;
    f0 = ferr_cnt;
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) hold(1'b1, BIT_CLK);
    hold(1'b1, 32);
    rst_n = 1'b0;
    #1;
    check("midrst_dout", int'(bus.dout), 0);
    check("midrst_done", int'(bus.rx_done_tick), 0);
    check("midrst_ferr", int'(bus.frame_err), 0);
    hold(1'b1, 10);
    rst_n = 1'b1;
    hold(1'b1, 20);
    send_frame(8'h12, 1'b1);
    hold(1'b1, GAP);
    check("midrst_done_cnt", done_cnt - d0, 1);
    check("midrst_ferr_cnt", ferr_cnt - f0, 0);
    check("midrst_dout_12", int'(bus.dout), 8'h12);

    // Five frames into the downstream buffer
    fifo_en = 1'b1;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    hold(1'b1, GAP);
    fifo_en = 1'b0;
    check("buf_count", fifo_cnt, 5);
    check("buf_full", int'(fifo_full), 1);
    for (int i = 0; i < 5; i++)
      check($sformatf("buf_entry%0d", i), int'(fifo[i]), i + 1);

    check("strobe_width", max_run, 1);
    check("strobes_exclusive", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_DIV, default 163, clk cycles per 16x oversample tick (163 gives 19200 baud at 50 MHz).
REQ-002 Parameter DBIT, default 8, data bits per frame.
REQ-003 Parameter SB_TICK, default 16, oversample ticks per stop bit.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-007 dout  output  DBIT  last correctly framed byte, LSB received first.
REQ-008 rx_done_tick  output  1  one-cycle strobe, dout valid; drives downstream buffer write enable.
REQ-009 frame_err  output  1  one-cycle strobe, stop bit sampled low.

Function
REQ-010 Tick generator SHALL be a free-running counter 0..CLK_DIV-1 asserting internal s_tick for one clk when count == CLK_DIV-1, then wrapping to 0.
REQ-011 rx SHALL pass a 2-flop synchronizer (reset value 1); the FSM uses only the synchronized value rx_s.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, with tick counter s (4 bit) and bit counter n (width ceil(log2(DBIT))).
REQ-013 IDLE: rx_s == 0 -> START, s = 0; evaluated every clk, independent of s_tick.
REQ-014 START: on s_tick, if s == 7 and rx_s == 0 -> DATA, s = 0, n = 0; if s == 7 and rx_s == 1 -> IDLE (glitch rejected, no strobe); else s++.
REQ-015 DATA: on s_tick, if s == 15 then s = 0, shift register b = {rx_s, b[DBIT-1:1]}, and n == DBIT-1 -> STOP else n++; else s++.
REQ-016 STOP: on s_tick, if s == SB_TICK-1 -> IDLE; else s++.
REQ-017 On STOP exit with rx_s == 1: dout <= b and rx_done_tick = 1 for exactly the next clk cycle.
REQ-018 On STOP exit with rx_s == 0: frame_err = 1 for exactly the next clk cycle; dout unchanged; rx_done_tick stays 0.
REQ-019 rx_done_tick and frame_err SHALL be registered and never both high.
REQ-020 dout SHALL hold its value between frames.
REQ-021 Outside IDLE, transitions SHALL occur only on s_tick cycles.
REQ-022 Back-to-back frames: a start edge in the first clk after STOP exit SHALL be accepted with no lost frame.
REQ-023 Break (rx held low): after frame_err, FSM re-enters START immediately and rejects nothing further until rx_s returns high through a valid frame; no rx_done_tick is produced with stop = 0.
REQ-024 Latency: rx_done_tick rises 1 clk after the s_tick ending stop-bit sampling.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, s = 0, n = 0, b = 0, tick counter 0, synchronizer flops 1, dout = 0, rx_done_tick = 0, frame_err = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no strobe; after release, reception resumes on the next falling edge of rx_s.
REQ-027 Reset release SHALL be consumed synchronously; first FSM evaluation occurs on the first rising clk edge after rst_n is high.

Verification
REQ-028 CLK_DIV=4, send 0x55 (8N1) -> one rx_done_tick, dout = 0x55, frame_err never 1.
REQ-029 Send 0xA3 then 0x3C with zero idle gap -> two rx_done_tick pulses, dout = 0xA3 then 0x3C, exactly one clk each.
REQ-030 rx low for 5 oversample ticks, then high -> FSM returns IDLE, no rx_done_tick, no frame_err, dout unchanged.
REQ-031 Send 0x7E with stop bit 0 -> frame_err one clk, rx_done_tick 0, dout retains prior 0x00.
REQ-032 Assert rst_n low during DATA bit 4 of 0xFF, release, send 0x12 -> only one rx_done_tick, dout = 0x12.
REQ-033 Five frames 0x01..0x05 into downstream 5-entry buffer -> five rx_done_tick pulses, buffer holds 0x01..0x05 and its full flag = 1.
